// File: rtl/lifo_arb_pkg.sv
// Shared definitions for the LIFO request arbiter.
//   state_t : FSM state encoding (IDLE/ISSUE/POP_WAIT/DONE)
//   OP_PUSH : requester op code for push (0)
//   OP_POP  : requester op code for pop  (1)
package lifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    POP_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req        in  NREQ  pending requests
//   last_grant in  IW    index granted most recently
//   grant      out NREQ  one-hot winner (all zero when no request)
//   grant_idx  out IW    index of the winner (0 when no request)
// The search starts at last_grant+1 and wraps at NREQ, so the requester
// that was just served has the lowest priority on the next pick.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  int idx;

  // Walk the offsets from farthest to nearest; the nearest set request
  // is written last and therefore wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/lifo_req_arbiter.sv
// Serialises push/pop requests from NREQ clients onto one LIFO stack.
//   clk, clr          clock and synchronous active-high reset
//   req/op/wdata      per-requester request, op (0 push, 1 pop), push data
//   flush             1-cycle pulse, empties the stack when seen in IDLE
//   ack/err/rdata     1-cycle completion pulse, reject flag, pop data
//   level             current stack occupancy (0..DEPTH)
//   lifo_push/pop/din/clr, lifo_dout   port to the attached LIFO
//   state             current FSM state, exported for observation
// Handshake: a requester raises req[i] with op/wdata stable and holds it
// until ack[i] pulses; it must drop req[i] by the edge ending the ack cycle
// or the still-high req is treated as a fresh request. op/wdata are
// captured only at grant. err is meaningful only while ack is high.
module lifo_req_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  op,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic             flush,
  output logic [NREQ-1:0]  ack,
  output logic             err,
  output logic [DW-1:0]    rdata,
  output logic [CW-1:0]    level,
  output logic             lifo_push,
  output logic             lifo_pop,
  output logic [DW-1:0]    lifo_din,
  output logic             lifo_clr,
  input  logic [DW-1:0]    lifo_dout,
  output state_t           state
);

  localparam int IW = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [IW-1:0]     gnt_q;
  logic [NREQ-1:0]   gnt_oh_q;
  logic [IW-1:0]     last_grant;
  logic              op_q;
  logic [DW-1:0]     data_q;
  logic              err_q;
  logic [CW-1:0]     level_q;
  logic [DW-1:0]     rdata_q;
  logic              flush_fire;

  logic [NREQ-1:0]   arb_grant;
  logic [IW-1:0]     arb_idx;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    lifo_push  = 1'b0;
    lifo_pop   = 1'b0;
    flush_fire = 1'b0;
    ack        = '0;
    err        = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) flush_fire = 1'b1;
        else if (|req) state_d = ISSUE;
      end
      ISSUE: begin
        if (op_q == OP_PUSH) begin
          // A full stack rejects the push without touching the LIFO.
          if (level_q != CW'(DEPTH)) lifo_push = 1'b1;
          state_d = DONE;
        end else if (level_q != '0) begin
          lifo_pop = 1'b1;
          state_d  = POP_WAIT;
        end else begin
          state_d = DONE;
        end
      end
      POP_WAIT: state_d = DONE;
      DONE: begin
        ack     = gnt_oh_q;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_oh_q   <= '0;
      last_grant <= IW'(NREQ - 1);
      op_q       <= OP_PUSH;
      data_q     <= '0;
      err_q      <= 1'b0;
      level_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (flush) begin
            level_q <= '0;
          end else if (|req) begin
            gnt_q    <= arb_idx;
            gnt_oh_q <= arb_grant;
            op_q     <= op[arb_idx];
            data_q   <= wdata[int'(arb_idx)*DW +: DW];
          end
        end
        ISSUE: begin
          if (lifo_push)     level_q <= level_q + CW'(1);
          else if (lifo_pop) level_q <= level_q - CW'(1);
          else               err_q   <= 1'b1;
        end
        // LIFO output is valid the cycle after lifo_pop.
        POP_WAIT: rdata_q <= lifo_dout;
        DONE: begin
          last_grant <= gnt_q;
          err_q      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign lifo_clr = clr | flush_fire;
  assign lifo_din = data_q;
  assign rdata    = rdata_q;
  assign level    = level_q;
  assign state    = state_q;

endmodule

// File: tb/tb_lifo_req_arbiter.sv
// Self-checking bench for lifo_req_arbiter with an emulated 8-entry LIFO
// and a queue-based reference model of the stack contents.
module tb_lifo_req_arbiter;
  import lifo_arb_pkg::*;

  localparam int NREQ  = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 clr = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0]      op = '0;
  logic [NREQ*DW-1:0]   wdata = '0;
  logic                 flush = 1'b0;
  logic [NREQ-1:0]      ack;
  logic                 err;
  logic [DW-1:0]        rdata;
  logic [CW-1:0]        level;
  logic                 lifo_push, lifo_pop, lifo_clr;
  logic [DW-1:0]        lifo_din;
  logic [DW-1:0]        lifo_dout = '0;
  state_t               state;

  lifo_req_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .req(req), .op(op), .wdata(wdata), .flush(flush),
    .ack(ack), .err(err), .rdata(rdata), .level(level),
    .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_din(lifo_din),
    .lifo_clr(lifo_clr), .lifo_dout(lifo_dout), .state(state)
  );

  int vectors = 0;
  int miscompares = 0;
  int push_pulses = 0;
  int pop_pulses = 0;
  int cyc = 0;

  // Reference model: stack contents, bottom at index 0.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rdata = '0;

  // ---------------- attached LIFO emulation ----------------
  logic [DW-1:0] mem [DEPTH];
  int sp = 0;
  always @(posedge clk) begin
    cyc++;
    if (lifo_clr) sp = 0;
    else if (lifo_push) begin
      if (sp < DEPTH) begin mem[sp] = lifo_din; sp++; end
    end else if (lifo_pop) begin
      if (sp > 0) begin sp--; lifo_dout <= mem[sp]; end
    end
  end

  // ---------------- per-cycle monitor ----------------
  always @(negedge clk) begin
    if (lifo_push) push_pulses++;
    if (lifo_pop) pop_pulses++;
    if (!clr) begin
      vectors++;
      if (int'(lifo_push) + int'(lifo_pop) + int'(lifo_clr) > 1) begin
        miscompares++;
        $display("FAIL strobe_excl push=%0b pop=%0b clr=%0b, at most one required", lifo_push, lifo_pop, lifo_clr);
      end
    end
    vectors++;
    if (err === 1'b1 && ack === '0) begin
      miscompares++;
      $display("FAIL err_without_ack err=%0b ack=%b, required err=0", err, ack);
    end
  end

  // ---------------- driver: one request through to its ack ----------------
  task automatic do_op(input int r, input logic o, input logic [DW-1:0] d, input string tag);
    int lat;
    bit got;
    logic exp_err;
    int exp_lat;
    if (o == OP_PUSH) begin
      exp_err = (exp_q.size() == DEPTH);
      if (!exp_err) exp_q.push_back(d);
      exp_lat = 2;
    end else begin
      exp_err = (exp_q.size() == 0);
      if (!exp_err) exp_rdata = exp_q.pop_back();
      exp_lat = exp_err ? 2 : 3;
    end
    req[r] = 1'b1;
    op[r] = o;
    wdata[r*DW +: DW] = d;
    lat = 0;
    got = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (ack[r] === 1'b1) begin got = 1; break; end
      lat++;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s ack_timeout got no ack, required ack[%0d]", tag, r);
    end else begin
      vectors += 5;
      if (lat !== exp_lat) begin miscompares++; $display("FAIL %s latency got=%0d exp=%0d", tag, lat, exp_lat); end
      if (err !== exp_err) begin miscompares++; $display("FAIL %s err got=%0b exp=%0b", tag, err, exp_err); end
      if (rdata !== exp_rdata) begin miscompares++; $display("FAIL %s rdata got=%h exp=%h", tag, rdata, exp_rdata); end
      if (level !== CW'(exp_q.size())) begin miscompares++; $display("FAIL %s level got=%0d exp=%0d", tag, level, exp_q.size()); end
      if (ack !== (NREQ'(1) << r)) begin miscompares++; $display("FAIL %s ack_vec got=%b exp=%b", tag, ack, NREQ'(1) << r); end
    end
    req[r] = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (ack !== '0) begin miscompares++; $display("FAIL %s ack_width got=%b exp=0 after ack cycle", tag, ack); end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (lifo_clr !== 1'b1) begin miscompares++; $display("FAIL reset_lifo_clr got=%b exp=1", lifo_clr); end
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    vectors += 8;
    if (state !== IDLE) begin miscompares++; $display("FAIL reset_state got=%0d exp=%0d", state, IDLE); end
    if (ack !== '0) begin miscompares++; $display("FAIL reset_ack got=%b exp=0", ack); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err); end
    if (rdata !== '0) begin miscompares++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    if (level !== '0) begin miscompares++; $display("FAIL reset_level got=%0d exp=0", level); end
    if (lifo_push !== 1'b0) begin miscompares++; $display("FAIL reset_push got=%b exp=0", lifo_push); end
    if (lifo_pop !== 1'b0) begin miscompares++; $display("FAIL reset_pop got=%b exp=0", lifo_pop); end
    if (lifo_clr !== 1'b0) begin miscompares++; $display("FAIL reset_clr_low got=%b exp=0", lifo_clr); end
    exp_q.delete();
    exp_rdata = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_push_pop();
    do_op(0, OP_PUSH, 8'h11, "pp_push11");
    do_op(0, OP_PUSH, 8'h22, "pp_push22");
    do_op(0, OP_PUSH, 8'h33, "pp_push33");
    do_op(0, OP_POP, 8'h00, "pp_pop33");
    do_op(0, OP_POP, 8'h00, "pp_pop22");
    do_op(0, OP_POP, 8'h00, "pp_pop11");
  endtask

  task automatic test_pop_empty();
    int p0;
    p0 = pop_pulses;
    do_op(1, OP_POP, 8'h00, "empty_pop");
    vectors++;
    if (pop_pulses !== p0) begin miscompares++; $display("FAIL empty_pop_strobe got=%0d pulses exp=0", pop_pulses - p0); end
  endtask

  task automatic test_full();
    int p0;
    for (int i = 0; i < DEPTH; i++)
      do_op($urandom_range(0, NREQ - 1), OP_PUSH, DW'($urandom_range(0, 255)), "full_fill");
    p0 = push_pulses;
    do_op($urandom_range(0, NREQ - 1), OP_PUSH, DW'($urandom_range(0, 255)), "full_ninth");
    vectors++;
    if (push_pulses !== p0) begin miscompares++; $display("FAIL full_push_strobe got=%0d pulses exp=0", push_pulses - p0); end
    for (int i = 0; i < DEPTH; i++)
      do_op($urandom_range(0, NREQ - 1), OP_POP, 8'h00, "full_drain");
  endtask

  // Both requesters push continuously; grants must alternate 0,1,0,1 and
  // acks must come every 3 cycles.
  task automatic test_round_robin();
    logic [DW-1:0] d [NREQ];
    int t_prev;
    bit got;
    for (int i = 0; i < NREQ; i++) begin
      d[i] = DW'($urandom_range(0, 255));
      wdata[i*DW +: DW] = d[i];
    end
    op = '0;
    req = '1;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int n = 0; n < 12; n++) begin
        @(negedge clk);
        if (ack !== '0) begin got = 1; break; end
      end
      vectors++;
      if (!got) begin
        miscompares++;
        $display("FAIL rr_timeout ack %0d never came", k);
      end else begin
        exp_q.push_back(d[k % NREQ]);
        vectors++;
        if (ack !== (NREQ'(1) << (k % NREQ))) begin miscompares++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, ack, NREQ'(1) << (k % NREQ)); end
        if (k > 0) begin
          vectors++;
          if (cyc - t_prev !== 3) begin miscompares++; $display("FAIL rr_spacing k=%0d got=%0d cycles exp=3", k, cyc - t_prev); end
        end
        t_prev = cyc;
      end
      if (k == 3) req = '0;
      @(negedge clk);
      vectors++;
      if (ack !== '0) begin miscompares++; $display("FAIL rr_ack_width k=%0d got=%b exp=0", k, ack); end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (level !== CW'(exp_q.size())) begin miscompares++; $display("FAIL rr_level got=%0d exp=%0d", level, exp_q.size()); end
    // Pop back in LIFO order through the normal path.
    for (int k = 0; k < 4; k++) do_op(k % NREQ, OP_POP, 8'h00, "rr_drain");
  endtask

  task automatic test_flush();
    int lat;
    bit got;
    for (int i = 0; i < 5; i++) do_op(0, OP_PUSH, DW'($urandom_range(0, 255)), "flush_fill");
    flush = 1'b1;
    req[0] = 1'b1;
    op[0] = OP_POP;
    @(negedge clk);
    vectors += 2;
    if (lifo_clr !== 1'b1) begin miscompares++; $display("FAIL flush_clr got=%b exp=1", lifo_clr); end
    if (lifo_pop !== 1'b0) begin miscompares++; $display("FAIL flush_no_pop got=%b exp=0", lifo_pop); end
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    vectors += 2;
    if (lifo_clr !== 1'b0) begin miscompares++; $display("FAIL flush_clr_width got=%b exp=0", lifo_clr); end
    if (level !== '0) begin miscompares++; $display("FAIL flush_level got=%0d exp=0", level); end
    got = 0;
    lat = 0;
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge clk);
      if (ack[0] === 1'b1) begin got = 1; lat = n; break; end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL flush_req0_timeout no ack, required ack[0]");
    end else begin
      vectors += 3;
      if (lat !== 2) begin miscompares++; $display("FAIL flush_req0_latency got=%0d exp=2", lat); end
      if (err !== 1'b1) begin miscompares++; $display("FAIL flush_pop_err got=%b exp=1", err); end
      if (rdata !== exp_rdata) begin miscompares++; $display("FAIL flush_rdata got=%h exp=%h", rdata, exp_rdata); end
    end
    req[0] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_clr_midop();
    bit got;
    do_op(0, OP_PUSH, DW'($urandom_range(0, 255)), "clr_fill");
    req[1] = 1'b1;
    op[1] = OP_POP;
    got = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (state === POP_WAIT) begin got = 1; break; end
    end
    vectors++;
    if (!got) begin miscompares++; $display("FAIL clr_reach_popwait state=%0d exp=%0d", state, POP_WAIT); end
    clr = 1'b1;
    #1;
    vectors++;
    if (lifo_clr !== 1'b1) begin miscompares++; $display("FAIL clr_lifo_clr got=%b exp=1", lifo_clr); end
    @(posedge clk);
    #1;
    clr = 1'b0;
    req = '0;
    exp_q.delete();
    exp_rdata = '0;
    vectors += 4;
    if (state !== IDLE) begin miscompares++; $display("FAIL clr_state got=%0d exp=%0d", state, IDLE); end
    if (level !== '0) begin miscompares++; $display("FAIL clr_level got=%0d exp=0", level); end
    if (ack !== '0) begin miscompares++; $display("FAIL clr_ack got=%b exp=0", ack); end
    if (rdata !== '0) begin miscompares++; $display("FAIL clr_rdata got=%h exp=0", rdata); end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      vectors++;
      if (ack !== '0) begin miscompares++; $display("FAIL clr_no_ack got=%b exp=0", ack); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      else do_op($urandom_range(0, NREQ - 1), logic'($urandom_range(0, 1)),
                 DW'($urandom_range(0, 255)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_pop_empty();
    test_full();
    test_round_robin();
    test_flush();
    test_clr_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
